snake_dir_ctrl: RTL and testbench
=================================

// Module: snake_dir_ctrl
// PURPOSE
//  Direction scheduler between the four debounced direction buttons and the snake movement engine.
//  - Edge-detects button presses and arbitrates simultaneous presses.
//  - Rejects reversals and duplicates, and buffers turns in a small queue.
//  - Releases one queued turn per game tick, so quick double-turns are never lost.
//  - Also sequences game run state: IDLE / RUN / PAUSE / DEAD.
// PARAMETERS
//  QUEUE_DEPTH  2      turn queue entries (1..4)
//  INIT_DIR     2'd2   direction after reset/restart (0=UP 1=DOWN 2=RIGHT 3=LEFT)
// PORTS
//  I_clk         in   1  system clock
//  I_rst_n       in   1  asynchronous active-low reset
//  I_button_u    in   1  debounced UP, active high
//  I_button_d    in   1  debounced DOWN, active high
//  I_button_r    in   1  debounced RIGHT, active high
//  I_button_l    in   1  debounced LEFT, active high
//  I_tick        in   1  one-cycle game step strobe
//  I_game_over   in   1  level/pulse from collision logic
//  O_dir         out  2  current movement direction
//  O_step        out  1  one-cycle pulse: engine advances one cell using O_dir
//  O_running     out  1  high in RUN
//  O_qcount      out  3  queued turn count
// BEHAVIOUR
//  Reset values: O_dir=INIT_DIR, O_step=0, O_running=0, O_qcount=0; FSM=IDLE; all edge registers 0.
//  Edge detect: press(k) = button(k) & ~button_d1(k). Edge is taken the same cycle; effects are visible next cycle.
//  Arbitration among simultaneous presses: fixed priority U > D > R > L; losers are discarded.
//  Opposite direction is dir^1.
//  Reference direction = newest queued entry, else O_dir.
//  Press enqueue rules:
//    - Dropped if equal to the reference direction or its opposite.
//    - Dropped if the queue is full.
//  IDLE:
//    - Any press -> RUN.
//    - That press is enqueued under the normal rules; e.g. LEFT with INIT_DIR=RIGHT is dropped, but RUN is still entered.
//    - Ticks are ignored.
//  RUN, on I_tick:
//    - Non-empty queue: pop head into O_dir.
//    - O_step=1 the next cycle, whether or not anything was popped.
//  Enqueue and pop in the same cycle: both occur; count is unchanged.
//    - Reference for the check is the pre-pop state; if the queue is empty, the check uses the old O_dir.
//  I_game_over (any state except IDLE) -> DEAD; has priority over the tick and over presses that cycle.
//    - Flush queue; O_step=0; O_running=0.
//  DEAD:
//    - Any press -> IDLE, O_dir=INIT_DIR.
//    - That press is consumed and not enqueued.
//  O_step never asserts outside RUN. Reset mid-operation returns everything to reset values immediately.
// CONFIGURATION
//  SNAKE_PAUSE_EN defined:
//    - Simultaneous U+D press edges in RUN -> PAUSE; in PAUSE -> RUN. Neither direction is enqueued.
//    - PAUSE ignores ticks and single presses; the queue is retained.
//  SNAKE_PAUSE_EN undefined:
//    - No PAUSE state; U+D resolves by priority to UP.
// STRUCTURE
//  Shared package snake_pkg:
//    - Direction codes DIR_UP/DN/RT/LT.
//    - FSM state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_DEAD.
//    - Function opposite(dir).
//  Sub-module dir_fifo: circular queue of 2-bit entries.
//    - Ports: push, pop, din, head, tail, count, flush.
//    - Simultaneous push+pop is supported when full or empty.
//  Top holds edge detect, arbiter and FSM.
// TESTING
//  1 Reset, press R -> RUN; press is dropped (duplicate), O_qcount=0; tick -> O_step next cycle, O_dir=2.
//  2 RUN dir=RIGHT: press U then L between ticks -> qcount=2; tick -> O_dir=0; tick -> O_dir=3.
//  3 RUN dir=RIGHT: press L -> dropped, qcount stays 0; U,D,R pressed same cycle -> only U queued.
//  4 Queue full (U,R queued for depth 2), press L -> dropped; press on tick cycle with qcount=1 -> count unchanged, new entry kept.
//  5 game_over asserted with tick in RUN -> DEAD, no O_step, qcount=0; press D -> IDLE, O_dir=2.
//  6 SNAKE_PAUSE_EN: U+D edge in RUN -> PAUSE, ticks give no O_step; U+D again -> RUN; without macro, U queued.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake direction scheduler: direction codes, run-state
// encodings and the reversal helper used by the enqueue filter.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP = 2'd0,
        DIR_DN = 2'd1,
        DIR_RT = 2'd2,
        DIR_LT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    localparam int MAX_QUEUE_DEPTH = 4;

    // Codes are paired so that flipping bit 0 yields the reverse heading.
    function automatic dir_e opposite(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Button/tick inputs and movement outputs of the direction scheduler.
// The master side drives buttons and ticks; the slave side is the scheduler.
interface snake_dir_ctrl_if;

    logic       I_button_u;
    logic       I_button_d;
    logic       I_button_r;
    logic       I_button_l;
    logic       I_tick;
    logic       I_game_over;
    logic [1:0] O_dir;
    logic       O_step;
    logic       O_running;
    logic [2:0] O_qcount;

    modport master (
        output I_button_u, I_button_d, I_button_r, I_button_l, I_tick, I_game_over,
        input  O_dir, O_step, O_running, O_qcount
    );

    modport slave (
        input  I_button_u, I_button_d, I_button_r, I_button_l, I_tick, I_game_over,
        output O_dir, O_step, O_running, O_qcount
    );

endinterface

// File: rtl/dir_fifo.sv
// Small circular queue of pending turns. Exposes both the oldest entry (head)
// and the newest one (tail), since the enqueue filter compares against the latter.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  dir_e       din,
    output dir_e       head,
    output dir_e       tail,
    output logic [2:0] count
);

    logic [1:0] rdPtr_q, rdPtr_d;
    logic [1:0] wrPtr_q, wrPtr_d;
    logic [2:0] count_q, count_d;
    logic [1:0] lastPtr;
    logic       doPush;
    logic       doPop;
    dir_e       mem_q [MAX_QUEUE_DEPTH];

    function automatic logic [1:0] nextPtr(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
    assign doPop   = pop && (count_q != 3'd0);
    assign doPush  = push && ((count_q != 3'(DEPTH)) || doPop);
    assign lastPtr = (wrPtr_q == 2'd0) ? 2'(DEPTH - 1) : wrPtr_q - 2'd1;

    assign head  = mem_q[rdPtr_q];
    assign tail  = mem_q[lastPtr];
    assign count = count_q;

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = 2'd0;
            wrPtr_d = 2'd0;
            count_d = 3'd0;
        end else begin
            if (doPush) wrPtr_d = nextPtr(wrPtr_q);
            if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= 2'd0;
            wrPtr_q <= 2'd0;
            count_q <= 3'd0;
            for (int i = 0; i < MAX_QUEUE_DEPTH; i++) mem_q[i] <= DIR_UP;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            if (!flush && doPush) mem_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Direction scheduler: button edge detect, fixed-priority arbitration, turn queue
// and IDLE/RUN/PAUSE/DEAD sequencing. Define SNAKE_PAUSE_EN to make U+D toggle PAUSE.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int         QUEUE_DEPTH = 2,
    parameter logic [1:0] INIT_DIR    = 2'd2
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    snake_dir_ctrl_if.slave bus
);

    logic [3:0] btnVec;
    logic [3:0] btnD1_q;
    logic [3:0] press;
    logic       anyPress;
    dir_e       selDir;
    dir_e       refDir;
    logic       accept;

    state_e     state_q, state_d;
    dir_e       dir_q, dir_d;
    logic       step_q, step_d;

    logic       fPush, fPop, fFlush;
    dir_e       fHead, fTail;
    logic [2:0] fCount;

    // Bit index equals the direction code, so arbitration is lowest-index-wins.
    assign btnVec   = {bus.I_button_l, bus.I_button_r, bus.I_button_d, bus.I_button_u};
    assign press    = btnVec & ~btnD1_q;
    assign anyPress = |press;

    always_comb begin
        selDir = DIR_LT;
        if (press[0])      selDir = DIR_UP;
        else if (press[1]) selDir = DIR_DN;
        else if (press[2]) selDir = DIR_RT;
    end

`ifdef SNAKE_PAUSE_EN
    logic pauseToggle;
    assign pauseToggle = press[0] & press[1];
`endif

    // Turns are filtered against the heading the snake will have once the queue drains.
    assign refDir = (fCount != 3'd0) ? fTail : dir_q;
    assign accept = anyPress
                 && (selDir != refDir)
                 && (selDir != opposite(refDir))
                 && (fCount != 3'(QUEUE_DEPTH));

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        fPush   = 1'b0;
        fPop    = 1'b0;
        fFlush  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (anyPress) begin
                    state_d = ST_RUN;
                    fPush   = accept;
                end
            end
            ST_RUN: begin
                if (bus.I_game_over) begin
                    state_d = ST_DEAD;
                    fFlush  = 1'b1;
                end
`ifdef SNAKE_PAUSE_EN
                else if (pauseToggle) begin
                    state_d = ST_PAUSE;
                end
`endif
                else begin
                    fPush = accept;
                    if (bus.I_tick) begin
                        step_d = 1'b1;
                        if (fCount != 3'd0) begin
                            fPop  = 1'b1;
                            dir_d = fHead;
                        end
                    end
                end
            end
`ifdef SNAKE_PAUSE_EN
            ST_PAUSE: begin
                if (bus.I_game_over) begin
                    state_d = ST_DEAD;
                    fFlush  = 1'b1;
                end else if (pauseToggle) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_DEAD: begin
                fFlush = 1'b1;
                if (!bus.I_game_over && anyPress) begin
                    state_d = ST_IDLE;
                    dir_d   = dir_e'(INIT_DIR);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            btnD1_q <= 4'b0000;
            state_q <= ST_IDLE;
            dir_q   <= dir_e'(INIT_DIR);
            step_q  <= 1'b0;
        end else begin
            btnD1_q <= btnVec;
            state_q <= state_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    dir_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .push  (fPush),
        .pop   (fPop),
        .flush (fFlush),
        .din   (selDir),
        .head  (fHead),
        .tail  (fTail),
        .count (fCount)
    );

    assign bus.O_dir     = dir_q;
    assign bus.O_step    = step_q;
    assign bus.O_running = (state_q == ST_RUN);
    assign bus.O_qcount  = fCount;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl: every expected O_step heading is queued
// when the tick is issued and matched by an independent monitor. Honors SNAKE_PAUSE_EN.
module tb_snake_dir_ctrl;

    localparam logic [1:0] UP = 2'd0;
    localparam logic [1:0] DN = 2'd1;
    localparam logic [1:0] RT = 2'd2;
    localparam logic [1:0] LT = 2'd3;

    logic       clk = 1'b0;
    logic       rstN;
    int         testsRun = 0;
    int         testsFailed = 0;
    logic [1:0] expQ [$];
    logic [1:0] monExp;

    always #5 clk = ~clk;

    snake_dir_ctrl_if bus ();

    snake_dir_ctrl dut (
        .I_clk   (clk),
        .I_rst_n (rstN),
        .bus     (bus.slave)
    );

    // Every step pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.O_step === 1'b1) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL step_unexpected: got O_step=1 with O_dir=%0d, required no step", bus.O_dir);
            end else begin
                monExp = expQ.pop_front();
                if (bus.O_dir !== monExp) begin
                    testsFailed++;
                    $display("[TB] FAIL step_dir: got O_dir=%0d, required %0d", bus.O_dir, monExp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [1:0] expDir,
                               input logic expRun, input logic [2:0] expCnt);
        testsRun++;
        if (bus.O_dir !== expDir) begin
            testsFailed++;
            $display("[TB] FAIL %s dir: got %0d, required %0d", name, bus.O_dir, expDir);
        end
        testsRun++;
        if (bus.O_running !== expRun) begin
            testsFailed++;
            $display("[TB] FAIL %s running: got %0b, required %0b", name, bus.O_running, expRun);
        end
        testsRun++;
        if (bus.O_qcount !== expCnt) begin
            testsFailed++;
            $display("[TB] FAIL %s qcount: got %0d, required %0d", name, bus.O_qcount, expCnt);
        end
    endtask

    // One-cycle input vector; when expStep is set, a step with expDir is expected next cycle.
    task automatic applyStimulus(input logic u, input logic d, input logic r, input logic l,
                                 input logic tick, input logic go,
                                 input logic expStep, input logic [1:0] expDir);
        @(negedge clk);
        bus.I_button_u  = u;
        bus.I_button_d  = d;
        bus.I_button_r  = r;
        bus.I_button_l  = l;
        bus.I_tick      = tick;
        bus.I_game_over = go;
        if (expStep) expQ.push_back(expDir);
        @(negedge clk);
        bus.I_button_u  = 1'b0;
        bus.I_button_d  = 1'b0;
        bus.I_button_r  = 1'b0;
        bus.I_button_l  = 1'b0;
        bus.I_tick      = 1'b0;
        bus.I_game_over = 1'b0;
    endtask

    initial begin
        bus.I_button_u  = 1'b0;
        bus.I_button_d  = 1'b0;
        bus.I_button_r  = 1'b0;
        bus.I_button_l  = 1'b0;
        bus.I_tick      = 1'b0;
        bus.I_game_over = 1'b0;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset", RT, 1'b0, 3'd0);
        rstN = 1'b1;

        // IDLE ignores ticks and game_over; a following press must still start the game.
        applyStimulus(0, 0, 0, 0, 1, 0, 0, UP);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, UP);
        checkOutput("idle_ignore", RT, 1'b0, 3'd0);

        applyStimulus(0, 0, 1, 0, 0, 0, 0, UP);
        checkOutput("start_dup", RT, 1'b1, 3'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, RT);
        checkOutput("first_tick", RT, 1'b1, 3'd0);

        // Double turn between ticks.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, UP);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, UP);
        checkOutput("queue_two", RT, 1'b1, 3'd2);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, UP);
        checkOutput("pop_one", UP, 1'b1, 3'd1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, LT);
        checkOutput("pop_two", LT, 1'b1, 3'd0);

        // Steer back to RIGHT, then reversal and arbitration.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, UP);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, UP);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, UP);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, RT);
        checkOutput("back_right", RT, 1'b1, 3'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, UP);
        checkOutput("reverse_drop", RT, 1'b1, 3'd0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, UP);
        checkOutput("arbitrate", RT, 1'b1, 3'd1);

        // Full queue, then push and pop in the same cycle.
        applyStimulus(0, 0, 1, 0, 0, 0, 0, UP);
        checkOutput("fill", RT, 1'b1, 3'd2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, UP);
        checkOutput("full_drop", RT, 1'b1, 3'd2);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, UP);
        checkOutput("pop_full", UP, 1'b1, 3'd1);
        applyStimulus(1, 0, 0, 0, 1, 0, 1, RT);
        checkOutput("push_pop", RT, 1'b1, 3'd1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, UP);
        checkOutput("kept_entry", UP, 1'b1, 3'd0);

        // game_over beats a simultaneous tick; restart from DEAD.
        applyStimulus(0, 0, 0, 1, 0, 0, 0, UP);
        checkOutput("pre_dead", UP, 1'b1, 3'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, UP);
        checkOutput("dead", UP, 1'b0, 3'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, UP);
        checkOutput("dead_tick", UP, 1'b0, 3'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, UP);
        checkOutput("restart", RT, 1'b0, 3'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, UP);
        checkOutput("idle_reverse", RT, 1'b1, 3'd0);

`ifdef SNAKE_PAUSE_EN
        applyStimulus(1, 1, 0, 0, 0, 0, 0, UP);
        checkOutput("pause", RT, 1'b0, 3'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, UP);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, UP);
        checkOutput("pause_hold", RT, 1'b0, 3'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, UP);
        checkOutput("resume", RT, 1'b1, 3'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, UP);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, UP);
        checkOutput("after_resume", UP, 1'b1, 3'd0);
`else
        applyStimulus(1, 1, 0, 0, 0, 0, 0, UP);
        checkOutput("ud_is_up", RT, 1'b1, 3'd1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, UP);
        checkOutput("ud_pop", UP, 1'b1, 3'd0);
`endif

        // Asynchronous reset mid-run.
        applyStimulus(0, 0, 0, 1, 0, 0, 0, UP);
        checkOutput("pre_reset", UP, 1'b1, 3'd1);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("mid_reset", RT, 1'b0, 3'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 0, 1, 0, 0, 0, 0, UP);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, RT);
        checkOutput("post_reset", RT, 1'b1, 3'd0);

        @(negedge clk);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL steps_missing: got %0d outstanding steps, required 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
